regfile_scoreboard: RTL

- Parametrised integer register file for the RISC-V core, successor to the fixed 2-read/1-write file.
- Configurable numbers of read and write ports; write-to-read bypass on every read port.
- Per-register pending scoreboard: issue marks a destination busy, writeback clears it.
- Sits between decode/issue (read, reserve) and writeback (write, release).

---
 rtl/regfile_scoreboard_pkg.sv | 10 +
 rtl/regfile_bypass_mux.sv | 38 +++
 rtl/regfile_scoreboard.sv | 79 +++++++
 3 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// Shared defaults and types for the integer register file with pending scoreboard.
package regfile_scoreboard_pkg;

    localparam int unsigned REGISTER_WIDTH = 32;
    localparam int unsigned REGISTER_DEPTH = 32;
    localparam int unsigned REG_IDX_W      = $clog2(REGISTER_DEPTH);

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_bypass_mux.sv
// One read port: selects forwarded write data (highest matching write port) or the
// stored register value, and produces the operand-ready flag.
module regfile_bypass_mux
    import regfile_scoreboard_pkg::*;
#(
    parameter int unsigned XLEN      = REGISTER_WIDTH,
    parameter int unsigned ADDR_W    = REG_IDX_W,
    parameter int unsigned NUM_WRITE = 1,
    parameter int unsigned BYPASS    = 1
) (
    input  logic                             rst,
    input  logic [ADDR_W-1:0]                rd_addr,
    input  logic [XLEN-1:0]                  stored_data,
    input  logic                             stored_pending,
    input  logic [NUM_WRITE-1:0]             wr_en,
    input  logic [NUM_WRITE-1:0][ADDR_W-1:0] wr_addr,
    input  logic [NUM_WRITE-1:0][XLEN-1:0]   wr_data,
    output logic [XLEN-1:0]                  rd_data,
    output logic                             rd_ready
);

    // Later (higher-index) matching write ports override earlier ones; x0 never forwards.
    always_comb begin
        rd_data  = stored_data;
        rd_ready = !stored_pending;
        for (int w = 0; w < NUM_WRITE; w++) begin
            if ((BYPASS != 0) && wr_en[w] && (wr_addr[w] == rd_addr) && (rd_addr != '0)) begin
                rd_data  = wr_data[w];
                rd_ready = 1'b1;
            end
        end
        if (rst) begin
            rd_data  = '0;
            rd_ready = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised integer register file with per-port write bypass and a pending-producer
// scoreboard: issue reserves a destination, writeback stores data and releases it.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int unsigned XLEN      = REGISTER_WIDTH,
    parameter int unsigned NUM_REGS  = REGISTER_DEPTH,
    parameter int unsigned NUM_READ  = 2,
    parameter int unsigned NUM_WRITE = 1,
    parameter int unsigned BYPASS    = 1,
    parameter int unsigned ADDR_W    = $clog2(NUM_REGS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_READ-1:0][ADDR_W-1:0]  rd_addr,
    output logic [NUM_READ-1:0][XLEN-1:0]    rd_data,
    output logic [NUM_READ-1:0]              rd_ready,
    input  logic [NUM_WRITE-1:0]             wr_en,
    input  logic [NUM_WRITE-1:0][ADDR_W-1:0] wr_addr,
    input  logic [NUM_WRITE-1:0][XLEN-1:0]   wr_data,
    input  logic                             rsv_en,
    input  logic [ADDR_W-1:0]                rsv_addr,
    output logic [NUM_REGS-1:0]              pending
);

    logic [NUM_REGS-1:0][XLEN-1:0] regs_q;
    logic [NUM_REGS-1:0]           pending_q;

    // Register storage: highest write port wins on a shared index; x0 is never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '0;
        end else begin
            for (int w = 0; w < NUM_WRITE; w++) begin
                if (wr_en[w] && (wr_addr[w] != '0)) begin
                    regs_q[wr_addr[w]] <= wr_data[w];
                end
            end
        end
    end

    // Scoreboard: writeback clears, reservation sets last so a new producer wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            for (int w = 0; w < NUM_WRITE; w++) begin
                if (wr_en[w] && (wr_addr[w] != '0)) begin
                    pending_q[wr_addr[w]] <= 1'b0;
                end
            end
            if (rsv_en && (rsv_addr != '0)) begin
                pending_q[rsv_addr] <= 1'b1;
            end
        end
    end

    assign pending = pending_q;

    for (genvar r = 0; r < NUM_READ; r++) begin : g_rd
        regfile_bypass_mux #(
            .XLEN      (XLEN),
            .ADDR_W    (ADDR_W),
            .NUM_WRITE (NUM_WRITE),
            .BYPASS    (BYPASS)
        ) u_mux (
            .rst            (rst),
            .rd_addr        (rd_addr[r]),
            .stored_data    (regs_q[rd_addr[r]]),
            .stored_pending (pending_q[rd_addr[r]]),
            .wr_en          (wr_en),
            .wr_addr        (wr_addr),
            .wr_data        (wr_data),
            .rd_data        (rd_data[r]),
            .rd_ready       (rd_ready[r])
        );
    end

endmodule
